// File: rtl/cond_logic_pipe.sv
// Condition-check stage: gates decoder writes on NZCV, tracks in-flight
// flag writes through a fixed-latency pipe, and saves/restores flags.
module cond_logic_pipe #(
  parameter int FLAG_LAT = 2,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Valid,
  input  logic [3:0]                 Cond,
  input  logic [1:0]                 FlagW,
  input  logic                       PCS,
  input  logic                       RegW,
  input  logic                       MemW,
  input  logic                       NoWrite,
  input  logic [3:0]                 ALUFlags,
  input  logic                       FlagPush,
  input  logic                       FlagPop,
  output logic                       PCSrc,
  output logic                       RegWrite,
  output logic                       MemWrite,
  output logic                       Stall,
  output logic [3:0]                 Flags,
  output logic [$clog2(DEPTH+1)-1:0] StackDepth,
  output logic                       StackErr
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]    flags_q, flags_d;
  logic [1:0]    pipe_q [FLAG_LAT];
  logic [1:0]    pipe_d [FLAG_LAT];
  logic [3:0]    stk_q  [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic          err_q, err_d;

  logic [3:0]    flags_e;
  logic          pend, pend_e;
  logic          n, z, c, v;
  logic          condex;
  logic          accept;
  logic [1:0]    wb;
  logic          full, empty;
  logic          push_ok, pop_ok, misuse;
  logic [AW-1:0] wr_idx, top_idx;

  // During reset the gating sees the post-reset architectural state.
  assign flags_e = reset ? 4'b0000 : flags_q;

  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < FLAG_LAT; i++)
      pend = pend | (|pipe_q[i]);
  end

  assign pend_e = pend & ~reset;
  assign {n, z, c, v} = flags_e;

  always_comb begin
    unique case (Cond)
      4'b0000: condex = z;
      4'b0001: condex = ~z;
      4'b0010: condex = c;
      4'b0011: condex = ~c;
      4'b0100: condex = n;
      4'b0101: condex = ~n;
      4'b0110: condex = v;
      4'b0111: condex = ~v;
      4'b1000: condex = c & ~z;
      4'b1001: condex = ~c | z;
      4'b1010: condex = (n == v);
      4'b1011: condex = (n != v);
      4'b1100: condex = ~z & (n == v);
      4'b1101: condex = z | (n != v);
      4'b1110: condex = 1'b1;
      4'b1111: condex = 1'b0;
    endcase
  end

  assign Stall    = Valid & pend_e & (Cond != 4'b1110);
  assign accept   = Valid & ~Stall;
  assign PCSrc    = accept & PCS & condex;
  assign RegWrite = accept & RegW & condex & ~NoWrite;
  assign MemWrite = accept & MemW & condex;

  always_comb begin
    pipe_d[0] = accept ? (FlagW & {2{condex}}) : 2'b00;
    for (int i = 1; i < FLAG_LAT; i++)
      pipe_d[i] = pipe_q[i-1];
  end

  assign wb      = pipe_q[FLAG_LAT-1];
  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
  assign push_ok = FlagPush & ~FlagPop & ~full;
  assign pop_ok  = FlagPop & ~FlagPush & ~empty;
  assign misuse  = (FlagPush & FlagPop) | (FlagPush & full)
                 | (FlagPop & empty);
  assign wr_idx  = AW'(depth_q);
  assign top_idx = AW'(depth_q - 1'b1);

  always_comb begin
    flags_d = flags_q;
    depth_d = depth_q;
    err_d   = err_q | misuse;
    if (wb[1]) flags_d[3:2] = ALUFlags[3:2];
    if (wb[0]) flags_d[1:0] = ALUFlags[1:0];
    // A restore wins over a writeback landing in the same cycle.
    if (pop_ok) begin
      flags_d = stk_q[top_idx];
      depth_d = depth_q - 1'b1;
    end
    if (push_ok) depth_d = depth_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < FLAG_LAT; i++)
        pipe_q[i] <= 2'b00;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      for (int i = 0; i < FLAG_LAT; i++)
        pipe_q[i] <= pipe_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok)
      stk_q[wr_idx] <= flags_q;
  end

  assign Flags      = flags_q;
  assign StackDepth = depth_q;
  assign StackErr   = err_q;

endmodule

// File: doc/cond_logic_pipe.md
COND_LOGIC_PIPE -- requirements
Module: cond_logic_pipe

Interface
REQ-001 SHALL have parameter FLAG_LAT, default 2, range 1..4: cycles from instruction accept to its ALUFlags arriving.
REQ-002 SHALL have parameter DEPTH, default 4, range 1..8: number of flag save-stack entries.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 Valid  in  1  instruction present at condition stage.
REQ-007 Cond  in  4  ARM condition code.
REQ-008 FlagW  in  2  [1]=update NZ, [0]=update CV.
REQ-009 PCS, RegW, MemW, NoWrite  in  1 each  decoder write requests.
REQ-010 ALUFlags  in  4  NZCV result, valid FLAG_LAT cycles after the producing accept.
REQ-011 FlagPush, FlagPop  in  1 each  save/restore Flags (exception entry/return).
REQ-012 PCSrc, RegWrite, MemWrite  out  1 each  gated write enables (combinational).
REQ-013 Stall  out  1  condition stage must hold (combinational).
REQ-014 Flags  out  4  architectural NZCV register.
REQ-015 StackDepth  out  $clog2(DEPTH+1)  occupied stack entries.
REQ-016 StackErr  out  1  sticky stack misuse flag.

Function
REQ-017 CondEx SHALL decode from Flags: 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0.
REQ-018 Pending SHALL be high when any pipeline stage holds a nonzero flag-write enable.
REQ-019 Stall SHALL equal Valid & Pending & (Cond != 1110).
REQ-020 Accept SHALL equal Valid & ~Stall.
REQ-021 PCSrc = Accept&PCS&CondEx; RegWrite = Accept&RegW&CondEx&~NoWrite; MemWrite = Accept&MemW&CondEx.
REQ-022 On Accept, FlagW&{2{CondEx}} SHALL enter a FLAG_LAT-stage shift pipe; otherwise 2'b00 enters; the pipe advances every cycle.
REQ-023 When the pipe output enable is nonzero, Flags[3:2] and/or Flags[1:0] SHALL load ALUFlags per enable bit at that edge.
REQ-024 An AL instruction accepted while Pending SHALL not modify the order of earlier writes; younger writes land strictly after older ones.
REQ-025 FlagPush alone, StackDepth<DEPTH: push Flags value before any same-cycle writeback; StackDepth+1.
REQ-026 FlagPop alone, StackDepth>0: Flags load top entry; StackDepth-1; overrides a same-cycle pipe writeback, which is discarded.
REQ-027 Push when StackDepth==DEPTH, Pop when StackDepth==0, or Push&Pop together: no stack/Flags change from the stack op; StackErr set and held until reset.
REQ-028 Stack ops SHALL not affect Stall, the pipe, or write-enable outputs.

Reset
REQ-029 On reset: Flags=0000, pipe cleared (Pending=0), StackDepth=0, StackErr=0; stack contents need not clear.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight flag writes; ALUFlags arriving afterward are ignored.
REQ-031 During reset cycle, outputs SHALL follow REQ-019..021 using reset-state values of Flags/Pending.

Verification
REQ-032 After reset, Valid=1,Cond=0000,RegW=1 -> RegWrite=1 (Z=0? no: Flags=0 so EQ false) -> RegWrite=0; Cond=0001 -> RegWrite=1.
REQ-033 FLAG_LAT=2: accept FlagW=11 Cond=1110, ALUFlags=0100 two cycles later; next Valid Cond=0000 -> Stall=1 for 2 cycles, then RegWrite=1 with Flags=0100.
REQ-034 Flagged instruction with failing Cond -> no pipe entry, Pending=0, Flags unchanged, following EQ instruction not stalled.
REQ-035 DEPTH=4: 5 pushes -> StackDepth=4, StackErr=1; 4 pops restore saved values in LIFO order; extra pop keeps StackDepth=0.
REQ-036 Pop coincident with writeback ALUFlags=1111 -> Flags equal popped value, not 1111.
REQ-037 Reset asserted one cycle after flag-setting accept -> Flags stay 0000 after ALUFlags arrive; Pending=0.
